// File: rtl/display_pkg.sv
// Shared timing descriptions and helpers for the display timing generator.
package display_pkg;

  typedef struct packed {
    int res;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } timing_t;

  localparam timing_t TIMING_640X480 = '{
    h: '{res: 640, fp: 16, sync: 96, bp: 48},
    v: '{res: 480, fp: 10, sync: 2, bp: 33}
  };

  localparam timing_t TIMING_1280X720 = '{
    h: '{res: 1280, fp: 110, sync: 40, bp: 220},
    v: '{res: 720, fp: 5, sync: 5, bp: 20}
  };

  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;

  function automatic int blank_len(input int fp, input int sync, input int bp);
    return fp + sync + bp;
  endfunction

  function automatic int coord_max(input int cordw);
    return (1 << (cordw - 1)) - 1;
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One timing axis: signed position counter running -(blanking)..RES-1 with wrap,
// plus sync-window, active-window and start-of-axis decodes of the current count.
module timing_axis
  import display_pkg::*;
#(
  parameter int CORDW = 16,
  parameter int RES   = 640,
  parameter int FP    = 16,
  parameter int SYNC  = 96,
  parameter int BP    = 48
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    advance_i,
  output logic signed [CORDW-1:0] pos_o,
  output logic                    wrap_o,
  output logic                    sync_o,
  output logic                    active_o,
  output logic                    start_o
);

  localparam int STA_I = -blank_len(FP, SYNC, BP);
  localparam logic signed [CORDW-1:0] STA      = CORDW'(STA_I);
  localparam logic signed [CORDW-1:0] POS_END  = CORDW'(RES - 1);
  localparam logic signed [CORDW-1:0] SYNC_BEG = CORDW'(STA_I + FP);
  localparam logic signed [CORDW-1:0] SYNC_END = CORDW'(STA_I + FP + SYNC - 1);
  localparam logic signed [CORDW-1:0] ONE      = CORDW'(1);
  localparam logic signed [CORDW-1:0] ZERO     = '0;

  // Both ends of the counter range must be representable as signed coordinates.
  if (RES > coord_max(CORDW) || blank_len(FP, SYNC, BP) > coord_max(CORDW)) begin : g_range_check
    $error("timing_axis: timing does not fit in CORDW-bit signed coordinates");
  end

  logic signed [CORDW-1:0] cnt_q, cnt_d;
  logic                    at_end;

  assign at_end = (cnt_q == POS_END);

  always_comb begin
    cnt_d = cnt_q;
    if (advance_i) begin
      cnt_d = at_end ? STA : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      cnt_q <= STA;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pos_o    = cnt_q;
  assign wrap_o   = advance_i && at_end;
  assign sync_o   = (cnt_q >= SYNC_BEG) && (cnt_q <= SYNC_END);
  assign active_o = (cnt_q >= ZERO);
  assign start_o  = (cnt_q == STA);

endmodule

// File: rtl/display_timings.sv
// Display timing generator: nested horizontal/vertical axes, every output registered
// from the current (x,y) so sync, de, pulses and coordinates stay cycle-aligned.
module display_timings
  import display_pkg::*;
#(
  parameter int   CORDW  = 16,
  parameter int   H_RES  = TIMING_640X480.h.res,
  parameter int   H_FP   = TIMING_640X480.h.fp,
  parameter int   H_SYNC = TIMING_640X480.h.sync,
  parameter int   H_BP   = TIMING_640X480.h.bp,
  parameter int   V_RES  = TIMING_640X480.v.res,
  parameter int   V_FP   = TIMING_640X480.v.fp,
  parameter int   V_SYNC = TIMING_640X480.v.sync,
  parameter int   V_BP   = TIMING_640X480.v.bp,
  parameter logic H_POL  = POL_NEG,
  parameter logic V_POL  = POL_NEG
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame,
  output logic                    line,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic [1:0]              ctrl_ch0
);

  localparam logic signed [CORDW-1:0] H_STA = CORDW'(-blank_len(H_FP, H_SYNC, H_BP));
  localparam logic signed [CORDW-1:0] V_STA = CORDW'(-blank_len(V_FP, V_SYNC, V_BP));

  logic signed [CORDW-1:0] h_pos, v_pos;
  logic h_wrap, h_sync, h_act, h_start;
  logic v_wrap_unused, v_sync, v_act, v_start;

  timing_axis #(
    .CORDW(CORDW), .RES(H_RES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk_pix  (clk_pix),
    .rst_pix_n(rst_pix_n),
    .advance_i(1'b1),
    .pos_o    (h_pos),
    .wrap_o   (h_wrap),
    .sync_o   (h_sync),
    .active_o (h_act),
    .start_o  (h_start)
  );

  // The vertical axis steps once per line, on the horizontal wrap.
  timing_axis #(
    .CORDW(CORDW), .RES(V_RES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk_pix  (clk_pix),
    .rst_pix_n(rst_pix_n),
    .advance_i(h_wrap),
    .pos_o    (v_pos),
    .wrap_o   (v_wrap_unused),
    .sync_o   (v_sync),
    .active_o (v_act),
    .start_o  (v_start)
  );

  logic signed [CORDW-1:0] sx_q, sy_q;
  logic hsync_q, vsync_q, de_q, frame_q, line_q;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sx_q    <= H_STA;
      sy_q    <= V_STA;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
      line_q  <= 1'b0;
    end else begin
      sx_q    <= h_pos;
      sy_q    <= v_pos;
      hsync_q <= h_sync ? H_POL : ~H_POL;
      vsync_q <= v_sync ? V_POL : ~V_POL;
      de_q    <= h_act && v_act;
      frame_q <= h_start && v_start;
      line_q  <= h_start;
    end
  end

  assign sx       = sx_q;
  assign sy       = sy_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign de       = de_q;
  assign frame    = frame_q;
  assign line     = line_q;
  assign ctrl_ch0 = {vsync_q, hsync_q};

endmodule

// File: tb/tb_display_timings.sv
// Bench for display_timings: three instances (640x480, 1280x720 active-high, tiny timing)
// compared every cycle against an arithmetic position model, plus vectors and run-length checks.
module tb_display_timings;

  localparam int CW = 16;

  typedef struct {
    int hres, hfp, hsy, hbp, vres, vfp, vsy, vbp;
    logic hpol, vpol;
  } cfg_t;

  typedef struct packed {
    logic signed [CW-1:0] sx;
    logic signed [CW-1:0] sy;
    logic hs, vs, de, ln, fr;
    logic [1:0] ctrl;
  } obs_t;

  typedef struct {
    int k;
    int sx, sy;
    logic hs, vs, de, ln, fr;
  } vec_t;

  logic clk_pix = 1'b0;
  logic rst_pix_n = 1'b1;
  always #5 clk_pix = ~clk_pix;

  logic d_hs, d_vs, d_de, d_fr, d_ln; logic signed [CW-1:0] d_sx, d_sy; logic [1:0] d_ctrl;
  logic c_hs, c_vs, c_de, c_fr, c_ln; logic signed [CW-1:0] c_sx, c_sy; logic [1:0] c_ctrl;
  logic s_hs, s_vs, s_de, s_fr, s_ln; logic signed [CW-1:0] s_sx, s_sy; logic [1:0] s_ctrl;

  display_timings u_dflt (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .frame(d_fr), .line(d_ln), .sx(d_sx), .sy(d_sy), .ctrl_ch0(d_ctrl)
  );

  display_timings #(
    .CORDW(16), .H_RES(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_RES(720), .V_FP(5), .V_SYNC(5), .V_BP(20), .H_POL(1'b1), .V_POL(1'b1)
  ) u_hd (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .hsync(c_hs), .vsync(c_vs), .de(c_de),
    .frame(c_fr), .line(c_ln), .sx(c_sx), .sy(c_sy), .ctrl_ch0(c_ctrl)
  );

  display_timings #(
    .CORDW(16), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1'b0), .V_POL(1'b1)
  ) u_tiny (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .frame(s_fr), .line(s_ln), .sx(s_sx), .sy(s_sy), .ctrl_ch0(s_ctrl)
  );

  obs_t a_d, a_c, a_s;
  assign a_d = {d_sx, d_sy, d_hs, d_vs, d_de, d_ln, d_fr, d_ctrl};
  assign a_c = {c_sx, c_sy, c_hs, c_vs, c_de, c_ln, c_fr, c_ctrl};
  assign a_s = {s_sx, s_sy, s_hs, s_vs, s_de, s_ln, s_fr, s_ctrl};

  // Clock edges seen since reset was last released.
  longint k;
  always @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) k <= 0;
    else k <= k + 1;
  end

  int errors = 0;
  int checks = 0;
  cfg_t cfg_d, cfg_c, cfg_s;
  vec_t tbl[$];
  int ti;

  // Position after kk edges is pure arithmetic on the cycle index within a frame.
  function automatic obs_t model(input cfg_t c, input longint kk);
    obs_t o;
    longint hsta, vsta, hl, fl, pos, x, y;
    hsta = -(c.hfp + c.hsy + c.hbp);
    vsta = -(c.vfp + c.vsy + c.vbp);
    hl = c.hres - hsta;
    fl = c.vres - vsta;
    if (kk == 0) begin
      x = hsta; y = vsta;
    end else begin
      pos = (kk - 1) % (hl * fl);
      x = hsta + pos % hl;
      y = vsta + pos / hl;
    end
    o.sx = CW'(x);
    o.sy = CW'(y);
    o.hs = (kk != 0 && x >= hsta + c.hfp && x < hsta + c.hfp + c.hsy) ? c.hpol : ~c.hpol;
    o.vs = (kk != 0 && y >= vsta + c.vfp && y < vsta + c.vfp + c.vsy) ? c.vpol : ~c.vpol;
    o.de = (kk != 0) && (x >= 0) && (y >= 0);
    o.ln = (kk != 0) && (x == hsta);
    o.fr = o.ln && (y == vsta);
    o.ctrl = {o.vs, o.hs};
    return o;
  endfunction

  task automatic check_obs(input string nm, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s k=%0d: got sx=%0d sy=%0d hs=%b vs=%b de=%b line=%b frame=%b ctrl=%b, want sx=%0d sy=%0d hs=%b vs=%b de=%b line=%b frame=%b ctrl=%b",
               nm, k, a.sx, a.sy, a.hs, a.vs, a.de, a.ln, a.fr, a.ctrl,
               e.sx, e.sy, e.hs, e.vs, e.de, e.ln, e.fr, e.ctrl);
    end
  endtask

  task automatic check_int(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d: got %0d, want %0d", nm, k, act, exp);
    end
  endtask

  task automatic check_all();
    check_obs("model_640x480", a_d, model(cfg_d, k));
    check_obs("model_1280x720", a_c, model(cfg_c, k));
    check_obs("model_tiny", a_s, model(cfg_s, k));
  endtask

  task automatic apply_tbl();
    obs_t e;
    while (ti < tbl.size() && longint'(tbl[ti].k) == k) begin
      e.sx = CW'(tbl[ti].sx); e.sy = CW'(tbl[ti].sy);
      e.hs = tbl[ti].hs; e.vs = tbl[ti].vs; e.de = tbl[ti].de;
      e.ln = tbl[ti].ln; e.fr = tbl[ti].fr; e.ctrl = {tbl[ti].vs, tbl[ti].hs};
      check_obs($sformatf("vec%0d", ti), a_d, e);
      $display("vec%0d k=%0d sx=%0d sy=%0d hsync=%b vsync=%b de=%b line=%b frame=%b",
               ti, k, d_sx, d_sy, d_hs, d_vs, d_de, d_ln, d_fr);
      ti++;
    end
  endtask

  // Run lengths and periods measured straight from the output waveforms.
  int d_hs_run, d_de_run, c_hs_run, s_de_cnt;
  longint d_last_line, c_last_line, s_last_frame;

  task automatic meas_reset();
    d_hs_run = 0; d_de_run = 0; c_hs_run = 0; s_de_cnt = 0;
    d_last_line = -1; c_last_line = -1; s_last_frame = -1;
  endtask

  task automatic meas();
    if (d_hs === 1'b0) d_hs_run++;
    else if (d_hs_run > 0) begin check_int("hsync_low_run_640", d_hs_run, 96); d_hs_run = 0; end
    if (d_de === 1'b1) d_de_run++;
    else if (d_de_run > 0) begin check_int("de_run_640", d_de_run, 640); d_de_run = 0; end
    if (d_ln === 1'b1) begin
      if (d_last_line >= 0) check_int("line_period_640", k - d_last_line, 800);
      d_last_line = k;
    end
    if (c_hs === 1'b1) c_hs_run++;
    else if (c_hs_run > 0) begin check_int("hsync_high_run_1280", c_hs_run, 40); c_hs_run = 0; end
    if (c_ln === 1'b1) begin
      if (c_last_line >= 0) check_int("line_period_1280", k - c_last_line, 1650);
      c_last_line = k;
    end
    if (s_fr === 1'b1) begin
      if (s_last_frame >= 0) begin
        check_int("frame_period_tiny", k - s_last_frame, 120);
        check_int("de_per_frame_tiny", s_de_cnt, 32);
      end
      s_last_frame = k;
      s_de_cnt = 0;
    end
    if (s_de === 1'b1) s_de_cnt++;
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    cfg_d = '{hres: 640, hfp: 16, hsy: 96, hbp: 48, vres: 480, vfp: 10, vsy: 2, vbp: 33, hpol: 1'b0, vpol: 1'b0};
    cfg_c = '{hres: 1280, hfp: 110, hsy: 40, hbp: 220, vres: 720, vfp: 5, vsy: 5, vbp: 20, hpol: 1'b1, vpol: 1'b1};
    cfg_s = '{hres: 8, hfp: 2, hsy: 3, hbp: 2, vres: 4, vfp: 1, vsy: 2, vbp: 1, hpol: 1'b0, vpol: 1'b1};

    //              k      sx    sy  hs vs de ln fr
    tbl.push_back('{0,     -160, -45, 1, 1, 0, 0, 0});
    tbl.push_back('{1,     -160, -45, 1, 1, 0, 1, 1});
    tbl.push_back('{2,     -159, -45, 1, 1, 0, 0, 0});
    tbl.push_back('{16,    -145, -45, 1, 1, 0, 0, 0});
    tbl.push_back('{17,    -144, -45, 0, 1, 0, 0, 0});
    tbl.push_back('{112,   -49,  -45, 0, 1, 0, 0, 0});
    tbl.push_back('{113,   -48,  -45, 1, 1, 0, 0, 0});
    tbl.push_back('{161,   0,    -45, 1, 1, 0, 0, 0});
    tbl.push_back('{801,   -160, -44, 1, 1, 0, 1, 0});
    tbl.push_back('{8000,  639,  -36, 1, 1, 0, 0, 0});
    tbl.push_back('{8001,  -160, -35, 1, 0, 0, 1, 0});
    tbl.push_back('{9600,  639,  -34, 1, 0, 0, 0, 0});
    tbl.push_back('{9601,  -160, -33, 1, 1, 0, 1, 0});
    tbl.push_back('{36161, 0,    0,   1, 1, 1, 0, 0});
    tbl.push_back('{36800, 639,  0,   1, 1, 1, 0, 0});
    tbl.push_back('{36801, -160, 1,   1, 1, 0, 1, 0});
    tbl.push_back('{44800, 639,  10,  1, 1, 1, 0, 0});
    tbl.push_back('{44801, -160, 11,  1, 1, 0, 1, 0});
    ti = 0;

    // Asynchronous reset before any clock edge.
    #1 rst_pix_n = 1'b0;
    #1;
    check_all();
    repeat (2) @(negedge clk_pix);
    check_all();
    apply_tbl();
    rst_pix_n = 1'b1;
    meas_reset();

    // Free run from reset through sy=11 of the 640x480 frame.
    for (int i = 0; i < 44810; i++) begin
      @(negedge clk_pix);
      check_all();
      meas();
      apply_tbl();
    end
    check_int("vectors_reached", ti, tbl.size());

    // Reset asserted in the middle of an hsync pulse.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk_pix);
      check_all();
      if (d_sx == -100) found = 1'b1;
    end
    check_int("found_sx_m100", found, 1);
    check_int("hsync_low_at_m100", d_hs, 0);
    #2 rst_pix_n = 1'b0;
    #1;
    check_int("async_rst_hsync", d_hs, 1);
    check_all();
    @(negedge clk_pix);
    check_all();
    rst_pix_n = 1'b1;
    $display("mid-line reset at sx=-100 applied and released");
    @(negedge clk_pix);
    check_int("restart_sx", d_sx, -160);
    check_int("restart_sy", d_sy, -45);
    check_int("restart_frame", d_fr, 1);
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk_pix);
      check_all();
    end

    // Random run lengths with resets at random points inside the low clock phase.
    for (int it = 0; it < 8; it++) begin
      int len;
      int dly;
      len = $urandom_range(1, 2000);
      dly = $urandom_range(1, 3);
      repeat (len) begin
        @(negedge clk_pix);
        check_all();
      end
      #dly rst_pix_n = 1'b0;
      #1;
      check_all();
      @(negedge clk_pix);
      check_all();
      rst_pix_n = 1'b1;
      $display("rand%0d: ran %0d cycles, reset %0d after falling edge", it, len, dly);
    end
    repeat (5) begin
      @(negedge clk_pix);
      check_all();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
